// File: rtl/lockin_pkg.sv
// -----------------------------------------------------------------------------
// lockin_pkg
// Shared definitions for the lock-in amplitude scheduler:
//   - sched_state_t  : scheduler FSM encoding (IDLE=0, RUN=1, CAPT=2, OUT=3)
//   - LOCKIN_N       : default operand / amplitude width
//   - LOCKIN_N_CH    : default number of lock-in channels
//   - LOCKIN_ENG_LAT : latency of the standard magnitude engine (N/2+4)
// -----------------------------------------------------------------------------
package lockin_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CAPT = 2'd2,
      ST_OUT  = 2'd3
   } sched_state_t;

   localparam int LOCKIN_N       = 64;
   localparam int LOCKIN_N_CH    = 4;
   localparam int LOCKIN_ENG_LAT = LOCKIN_N / 2 + 4;

endpackage

// File: rtl/lockin_amplitude_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// lockin_rr_arbiter
// Combinational round-robin search: returns the first pending channel found
// searching upward from rr_ptr, wrapping at N_CH.
// Ports:
//   pending     in  N_CH  per-channel pending flags
//   rr_ptr      in  CH_W  channel with highest priority this round
//   grant       out CH_W  selected channel (valid only when any_pending)
//   any_pending out 1     at least one channel is pending
// -----------------------------------------------------------------------------
module lockin_rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] pending,
   input  logic [CH_W-1:0] rr_ptr,
   output logic [CH_W-1:0] grant,
   output logic            any_pending
);

   // Rotate so that bit 0 is the channel at rr_ptr; the lowest set bit of
   // the rotated vector is the winner.
   logic [N_CH-1:0] rotated;

   assign rotated     = N_CH'({pending, pending} >> rr_ptr);
   assign any_pending = |pending;

   always_comb begin
      int pick;
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves it unassigned and no latch is inferred.
      pick = int'(rr_ptr);
      // Scan downward so the lowest rotated offset is the last one written.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            pick = int'(rr_ptr) + i;
            if (pick >= N_CH) pick = pick - N_CH;
         end
      end
      grant = CH_W'(pick);
   end

endmodule

// File: rtl/lockin_amplitude_scheduler.sv
// -----------------------------------------------------------------------------
// lockin_amplitude_scheduler
// Shares one magnitude/sqrt engine between N_CH lock-in channels. Each channel
// hands over one (fase, cuad) pair, which is buffered until a round-robin
// arbiter selects it; the engine is then driven with eng_valid held high until
// its done rising edge, and the amplitude is returned tagged with the channel.
//
// Optional feature (macro LOCKIN_SCHED_TIMEOUT_EN): an 8-bit RUN-cycle
// counter aborts a job after TIMEOUT cycles, pulses err and drops the request.
//
// Ports:
//   Clock, reset_n           clock (rising edge), async active-low reset
//   req_valid/req_ready      per-channel handshake, req_ready = slot free
//   req_fase/req_cuad        packed operands, channel i at [i*N +: N]
//   eng_valid/eng_fase/cuad  engine request, held for the whole job
//   eng_done/eng_amplitude   engine level done (rising edge = new result)
//   amp_valid/amp_ch/amp_data one-cycle tagged result
//   err                      one-cycle timeout strobe
// -----------------------------------------------------------------------------
module lockin_amplitude_scheduler
   import lockin_pkg::*;
#(
   parameter int N       = LOCKIN_N,
   parameter int N_CH    = LOCKIN_N_CH,
   parameter int CH_W    = 2,
   // Default leaves 60 cycles of headroom above the standard engine latency.
   parameter int TIMEOUT = LOCKIN_ENG_LAT + 60
) (
   input  logic              Clock,
   input  logic              reset_n,
   input  logic [N_CH-1:0]   req_valid,
   input  logic [N_CH*N-1:0] req_fase,
   input  logic [N_CH*N-1:0] req_cuad,
   output logic [N_CH-1:0]   req_ready,
   output logic              eng_valid,
   output logic [N-1:0]      eng_fase,
   output logic [N-1:0]      eng_cuad,
   input  logic              eng_done,
   input  logic [N-1:0]      eng_amplitude,
   output logic              amp_valid,
   output logic [CH_W-1:0]   amp_ch,
   output logic [N-1:0]      amp_data,
   output logic              err
);

   sched_state_t    state, state_nxt;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] accept;
   logic [N_CH-1:0] clr_mask;
   logic [N-1:0]    hold_fase [N_CH];
   logic [N-1:0]    hold_cuad [N_CH];
   logic [CH_W-1:0] rr_ptr;
   logic [CH_W-1:0] cur_ch;
   logic [CH_W-1:0] grant;
   logic            any_pending;
   logic            done_q;
   logic            done_edge;
   logic            tmo_hit;
   logic            job_end;

   assign req_ready = ~pending;
   // A valid on a pending channel is dropped, not queued.
   assign accept    = req_valid & ~pending;
   // done_q follows eng_done every cycle, so a done level left high by the
   // previous job is already in done_q when the next job starts.
   assign done_edge = eng_done & ~done_q;
   assign job_end   = (state == ST_CAPT) || tmo_hit;
   assign clr_mask  = job_end ? ({{(N_CH-1){1'b0}}, 1'b1} << cur_ch) : '0;

   lockin_rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .pending     (pending),
      .rr_ptr      (rr_ptr),
      .grant       (grant),
      .any_pending (any_pending)
   );

`ifdef LOCKIN_SCHED_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         tmo_cnt <= (state == ST_RUN) ? tmo_cnt + 8'd1 : 8'd0;
         err     <= tmo_hit;
      end
   end

   // tmo_cnt is 0 in the first RUN cycle; a done edge in the last cycle wins.
   assign tmo_hit = (state == ST_RUN) && !done_edge && (tmo_cnt == 8'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // eng_valid is decoded from the state so an async reset drops it at once.
   always_comb begin
      state_nxt = state;
      eng_valid = 1'b0;
      case (state)
         ST_IDLE: if (any_pending) state_nxt = ST_RUN;
         ST_RUN: begin
            eng_valid = 1'b1;
            if (done_edge)    state_nxt = ST_CAPT;
            else if (tmo_hit) state_nxt = ST_IDLE;
         end
         ST_CAPT: state_nxt = ST_OUT;   // engine registers amplitude here
         ST_OUT:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         pending   <= '0;
         rr_ptr    <= '0;
         cur_ch    <= '0;
         done_q    <= 1'b0;
         eng_fase  <= '0;
         eng_cuad  <= '0;
         amp_valid <= 1'b0;
         amp_ch    <= '0;
         amp_data  <= '0;
      end else begin
         done_q    <= eng_done;
         // accept and clear never hit the same bit: accept needs ~pending.
         pending   <= (pending & ~clr_mask) | accept;
         // Results are registered on the CAPT->OUT edge, so amp_valid is
         // high exactly while the FSM sits in OUT.
         amp_valid <= (state == ST_CAPT);

         if (state == ST_IDLE && any_pending) begin
            cur_ch   <= grant;
            eng_fase <= hold_fase[grant];
            eng_cuad <= hold_cuad[grant];
         end

         if (state == ST_CAPT) begin
            amp_data <= eng_amplitude;
            amp_ch   <= cur_ch;
         end

         if (job_end)
            rr_ptr <= (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + 1'b1;
      end
   end

   // NOTE: the holding registers have no reset; pending[i] alone says when
   // hold_*[i] holds meaningful data, so clearing them buys nothing.
   always_ff @(posedge Clock) begin
      for (int i = 0; i < N_CH; i++) begin
         if (accept[i]) begin
            hold_fase[i] <= req_fase[i*N +: N];
            hold_cuad[i] <= req_cuad[i*N +: N];
         end
      end
   end

endmodule
